// File: rtl/pc_ctrl.sv
// Program-counter sequencing controller: issues clear, hold and jump controls to
// the PC and tracks execution cycles with a saturating counter.
module pc_ctrl #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic          branch_cond,
  input  logic          stall,
  input  logic          halt_req,
  output logic          pcClear,
  output logic          pcHold,
  output logic          jumpEn,
  output logic [2:0]    jumpType,
  output logic          instrValid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycleCount
);

  localparam logic [2:0] OP_JUMP   = 3'b111;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_NONE   = 3'b000;

  // D only sizes the PC this block drives; reject meaningless widths at elaboration.
  if (D < 1 || CW < 1) begin : g_param_check
    $error("pc_ctrl: D and CW must be at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    FLUSH,
    HALT
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pcClear    = 1'b0;
    pcHold     = 1'b1;
    jumpEn     = 1'b0;
    jumpType   = OP_NONE;
    instrValid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        pcClear    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (start) begin
          state_next = CLEAR;
        end else if (stall) begin
          state_next = RUN;
        end else if (halt_req) begin
          // The halt instruction itself commits, but the PC stays on it.
          instrValid = 1'b1;
          state_next = HALT;
        end else if (opcode == OP_JUMP) begin
          jumpEn     = 1'b1;
          jumpType   = OP_JUMP;
          pcHold     = 1'b0;
          instrValid = 1'b1;
          state_next = FLUSH;
        end else if (opcode == OP_BRANCH && branch_cond) begin
          jumpEn     = 1'b1;
          jumpType   = OP_BRANCH;
          pcHold     = 1'b0;
          instrValid = 1'b1;
          state_next = FLUSH;
        end else begin
          pcHold     = 1'b0;
          instrValid = 1'b1;
        end
      end
      FLUSH: begin
        state_next = start ? CLEAR : RUN;
      end
      HALT: begin
        if (start) state_next = CLEAR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Counts every edge spent in RUN or FLUSH, pinned at all-ones once reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (state_reg == CLEAR) begin
      count_reg <= '0;
    end else if ((state_reg == RUN || state_reg == FLUSH) && count_reg != {CW{1'b1}}) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign busy       = (state_reg == CLEAR) || (state_reg == RUN) || (state_reg == FLUSH);
  assign done       = (state_reg == HALT);
  assign cycleCount = count_reg;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a flag-based behavioural model; a CW=4 copy exercises saturation.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  opcode;
  logic        branch_cond;
  logic        stall;
  logic        halt_req;

  logic        a_pcClear, a_pcHold, a_jumpEn, a_instrValid, a_busy, a_done;
  logic [2:0]  a_jumpType;
  logic [15:0] a_cycleCount;
  logic        b_pcClear, b_pcHold, b_jumpEn, b_instrValid, b_busy, b_done;
  logic [2:0]  b_jumpType;
  logic [3:0]  b_cycleCount;

  always #5 clk = ~clk;

  pc_ctrl #(.D(10), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_cond(branch_cond), .stall(stall), .halt_req(halt_req),
    .pcClear(a_pcClear), .pcHold(a_pcHold), .jumpEn(a_jumpEn),
    .jumpType(a_jumpType), .instrValid(a_instrValid), .busy(a_busy),
    .done(a_done), .cycleCount(a_cycleCount)
  );

  pc_ctrl #(.D(10), .CW(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .branch_cond(branch_cond), .stall(stall), .halt_req(halt_req),
    .pcClear(b_pcClear), .pcHold(b_pcHold), .jumpEn(b_jumpEn),
    .jumpType(b_jumpType), .instrValid(b_instrValid), .busy(b_busy),
    .done(b_done), .cycleCount(b_cycleCount)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: which phase the program is in, and an unbounded execution count.
  bit m_clear, m_run, m_flush, m_halt;
  int m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit run_active();
    return m_run && !start && !stall;
  endfunction

  function automatic bit take_jump();
    return run_active() && !halt_req && (opcode == 3'b111 || (opcode == 3'b001 && branch_cond));
  endfunction

  task automatic check_outputs(input string note);
    bit ra, tj;
    int e16, e4;
    ra  = run_active();
    tj  = take_jump();
    e16 = (m_count > 65535) ? 65535 : m_count;
    e4  = (m_count > 15) ? 15 : m_count;
    check({note, ".pcClear"},    32'(a_pcClear),    32'(m_clear));
    check({note, ".pcHold"},     32'(a_pcHold),     32'(!(ra && !halt_req)));
    check({note, ".jumpEn"},     32'(a_jumpEn),     32'(tj));
    check({note, ".jumpType"},   32'(a_jumpType),   tj ? 32'(opcode) : 32'd0);
    check({note, ".instrValid"}, 32'(a_instrValid), 32'(ra));
    check({note, ".busy"},       32'(a_busy),       32'(m_clear || m_run || m_flush));
    check({note, ".done"},       32'(a_done),       32'(m_halt));
    check({note, ".cycleCount"}, 32'(a_cycleCount), 32'(e16));
    check({note, ".cw4.count"},  32'(b_cycleCount), 32'(e4));
    check({note, ".cw4.ctl"},
          {27'd0, b_pcClear, b_pcHold, b_jumpEn, b_instrValid, b_done},
          {27'd0, a_pcClear, a_pcHold, a_jumpEn, a_instrValid, a_done});
    check({note, ".cw4.jt_busy"}, {28'd0, b_jumpType, b_busy}, {28'd0, a_jumpType, a_busy});
  endtask

  task automatic model_step();
    bit tj, n_clear, n_run, n_flush, n_halt;
    tj = take_jump();
    if (m_run || m_flush) m_count++;
    if (m_clear) m_count = 0;
    n_clear = 0; n_run = 0; n_flush = 0; n_halt = 0;
    if (start && !m_clear) n_clear = 1;
    else if (m_clear) n_run = 1;
    else if (m_run) begin
      if (stall) n_run = 1;
      else if (halt_req) n_halt = 1;
      else if (tj) n_flush = 1;
      else n_run = 1;
    end
    else if (m_flush) n_run = 1;
    else if (m_halt) n_halt = 1;
    m_clear = n_clear; m_run = n_run; m_flush = n_flush; m_halt = n_halt;
  endtask

  task automatic model_reset();
    m_clear = 0; m_run = 0; m_flush = 0; m_halt = 0; m_count = 0;
  endtask

  // Called at posedge+1; inputs held for the whole cycle.
  task automatic cycle(input bit s, input bit [2:0] op, input bit bc, input bit sl,
                       input bit hr, input string note);
    start = s; opcode = op; branch_cond = bc; stall = sl; halt_req = hr;
    #3;
    check_outputs(note);
    $display("cyc %0d %s: start=%0b op=%0d bc=%0b stall=%0b halt=%0b -> clr=%0b hold=%0b jmp=%0b jt=%0d iv=%0b busy=%0b done=%0b cnt=%0d cnt4=%0d",
             cyc, note, s, op, bc, sl, hr, a_pcClear, a_pcHold, a_jumpEn, a_jumpType,
             a_instrValid, a_busy, a_done, a_cycleCount, b_cycleCount);
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  // Asynchronous reset asserted between edges, with a jump-worthy opcode present.
  task automatic reset_mid(input string note);
    start = 0; opcode = 3'b111; branch_cond = 1; stall = 0; halt_req = 0;
    reset = 1;
    #1;
    model_reset();
    check_outputs({note, ".async"});
    $display("cyc %0d %s: reset asserted mid-cycle -> busy=%0b done=%0b cnt=%0d jmp=%0b clr=%0b",
             cyc, note, a_busy, a_done, a_cycleCount, a_jumpEn, a_pcClear);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs({note, ".held"});
    reset = 0;
  endtask

  initial begin
    reset = 0; start = 0; opcode = 0; branch_cond = 0; stall = 0; halt_req = 0;
    model_reset();
    #2 reset = 1;
    #1;
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    $display("cyc %0d reset: busy=%0b done=%0b cnt=%0d", cyc, a_busy, a_done, a_cycleCount);
    reset = 0;

    cycle(0, 3'b000, 0, 0, 0, "idle");
    cycle(1, 3'b000, 0, 0, 0, "start");
    cycle(0, 3'b000, 0, 0, 0, "clear");
    for (int i = 0; i < 5; i++) cycle(0, 3'b000, 0, 0, 0, "seq");
    check("seq5.count", 32'(a_cycleCount), 32'd5);

    cycle(0, 3'b111, 0, 0, 0, "jump");
    cycle(0, 3'b000, 0, 0, 0, "flush");
    cycle(0, 3'b000, 0, 0, 0, "seq");
    cycle(0, 3'b001, 0, 0, 0, "br_nt");
    cycle(0, 3'b001, 1, 0, 0, "br_t");
    cycle(0, 3'b111, 1, 1, 1, "flush_ign");
    cycle(0, 3'b000, 0, 0, 0, "seq");

    for (int i = 0; i < 3; i++) cycle(0, 3'b111, 0, 1, 0, "stall");
    cycle(0, 3'b111, 0, 0, 0, "jump_after_stall");
    cycle(0, 3'b000, 0, 0, 0, "flush");

    cycle(0, 3'b111, 0, 0, 1, "halt_jump");
    cycle(0, 3'b000, 0, 0, 0, "halted");
    cycle(0, 3'b111, 1, 1, 1, "halted");
    cycle(1, 3'b000, 0, 0, 0, "restart");
    cycle(0, 3'b000, 0, 0, 0, "clear");
    for (int i = 0; i < 20; i++) cycle(0, 3'b000, 0, 0, 0, "sat");
    check("sat.cw4", 32'(b_cycleCount), 32'd15);
    reset_mid("rst_run");
    cycle(0, 3'b000, 0, 0, 0, "idle");
    cycle(1, 3'b000, 0, 0, 0, "start");
    cycle(0, 3'b000, 0, 0, 0, "clear");

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_mid("rnd_rst");
      end else begin
        cycle($urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 14) == 0, "rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
